// File: rtl/mini_memoria_pkg.sv
// Shared sizing and word/address types for the 16x2 scratch RAM.
package mini_memoria_pkg;

  localparam int DATA_W = 2;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mini_memoria_word.sv
// One storage word: DATA_W-bit register with asynchronous clear and load enable.
module mini_memoria_word
  import mini_memoria_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  word_t d,
  output word_t q
);

  word_t word_d;
  word_t word_q;

  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/mini_memoria.sv
// Single-port 16x2 RAM built from clearable flops so reset can wipe every word at once;
// the read is registered and sees the old contents when the same address is written.
module mini_memoria
  import mini_memoria_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wre,
  input  logic [DATA_W-1:0] DEentrada,
  input  logic [ADDR_W-1:0] Direccion,
  output logic [DATA_W-1:0] DSalida
);

  word_t            word_out [DEPTH];
  logic [DEPTH-1:0] word_load;
  word_t            dout_d;
  word_t            dout_q;

  always_comb begin
    word_load = '0;
    if (wre) begin
      word_load[Direccion] = 1'b1;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    mini_memoria_word u_word (
      .clk  (clk),
      .rst  (rst),
      .load (word_load[k]),
      .d    (DEentrada),
      .q    (word_out[k])
    );
  end

  // The mux reads the pre-edge word, which gives read-before-write behaviour.
  always_comb begin
    dout_d = word_out[Direccion];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign DSalida = dout_q;

endmodule

// File: tb/tb_mini_memoria.sv
// Self-checking bench for mini_memoria: an array reference model plus literal spot checks.
module tb_mini_memoria;
  import mini_memoria_pkg::*;

  logic  clk;
  logic  rst;
  logic  wre;
  word_t DEentrada;
  addr_t Direccion;
  word_t DSalida;

  word_t ref_mem [DEPTH];
  word_t exp_out;
  logic  check_en;
  int    checks;
  int    errors;

  mini_memoria dut (
    .clk       (clk),
    .rst       (rst),
    .wre       (wre),
    .DEentrada (DEentrada),
    .Direccion (Direccion),
    .DSalida   (DSalida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input word_t act, input word_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: DSalida=%b expected=%b", name, $time, act, expv);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_out = '0;
  endtask

  // Drive one cycle of inputs and advance the model at the rising edge.
  task automatic applyStimulus(input logic we, input addr_t a, input word_t d);
    @(negedge clk);
    wre       = we;
    Direccion = a;
    DEentrada = d;
    @(posedge clk);
    if (!rst) begin
      exp_out = '0;
    end else begin
      exp_out = ref_mem[a];
      if (we) ref_mem[a] = d;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) checkOutput("model_compare", DSalida, exp_out);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    check_en  = 1'b0;
    rst       = 1'b1;
    wre       = 1'b0;
    Direccion = '0;
    DEentrada = '0;
    clearModel();

    // Reset with a write attempt held on the bus
    #2 rst = 1'b0;
    wre = 1'b1; Direccion = 4'd5; DEentrada = 2'b11;
    #1 checkOutput("reset_immediate", DSalida, 2'b00);
    check_en = 1'b1;
    applyStimulus(1'b1, 4'd5, 2'b11);
    applyStimulus(1'b1, 4'd5, 2'b11);
    #3 rst = 1'b1;
    applyStimulus(1'b0, 4'd5, 2'b00);
    #1 checkOutput("reset_write_blocked", DSalida, 2'b00);

    // Fill then read back
    for (int i = 0; i < DEPTH; i++) begin
      word_t v;
      v = word_t'(i) ^ 2'b01;
      applyStimulus(1'b1, addr_t'(i), v);
    end
    for (int i = 0; i < DEPTH; i++) begin
      word_t v;
      v = word_t'(i) ^ 2'b01;
      applyStimulus(1'b0, addr_t'(i), 2'b00);
      #1 checkOutput("fill_readback", DSalida, v);
    end

    // Read-during-write on the same address
    applyStimulus(1'b1, 4'd7, 2'b10);
    applyStimulus(1'b1, 4'd7, 2'b01);
    #1 checkOutput("rdw_old_value", DSalida, 2'b10);
    applyStimulus(1'b0, 4'd7, 2'b00);
    #1 checkOutput("rdw_new_value", DSalida, 2'b01);

    // Write disabled leaves the word alone
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd3, 2'b11);
    #1 checkOutput("write_disabled", DSalida, 2'b10);

    // Asynchronous reset between edges after non-zero contents
    applyStimulus(1'b0, 4'd2, 2'b00);
    #1 checkOutput("pre_reset_value", DSalida, 2'b11);
    #2 rst = 1'b0;
    clearModel();
    #1 checkOutput("async_reset_midcycle", DSalida, 2'b00);
    applyStimulus(1'b1, 4'd9, 2'b11);
    #3 rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, addr_t'(i), 2'b01);
      #1 checkOutput("post_reset_zero", DSalida, 2'b00);
    end

    // Randomized traffic against the reference array
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), addr_t'($urandom_range(0, DEPTH - 1)),
                    word_t'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
